// File: rtl/ofm_axi_wmst.sv
// AXI4 write master: splits an OFM transfer into INCR bursts that never cross a 4 KB boundary.
// Optional build macro OFM_WMST_BRESP_CHECK_EN enables the sticky xfer_err on non-OKAY bresp.
module ofm_axi_wmst #(
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wmst_req,
  input  logic [63:0]  wmst_addr,
  input  logic [63:0]  wmst_xfer_size,
  output logic         wmst_done,
  output logic         busy,
  output logic         xfer_err,
  input  logic         axis_slv_tvalid,
  output logic         axis_slv_tready,
  input  logic [511:0] axis_slv_tdata,
  output logic         m_axi_awvalid,
  input  logic         m_axi_awready,
  output logic [63:0]  m_axi_awaddr,
  output logic [7:0]   m_axi_awlen,
  output logic [2:0]   m_axi_awsize,
  output logic [1:0]   m_axi_awburst,
  output logic         m_axi_wvalid,
  input  logic         m_axi_wready,
  output logic [511:0] m_axi_wdata,
  output logic [63:0]  m_axi_wstrb,
  output logic         m_axi_wlast,
  input  logic         m_axi_bvalid,
  output logic         m_axi_bready,
  input  logic [1:0]   m_axi_bresp
);

  localparam int unsigned LenW = 7;
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAw    = 2'd1;
  localparam logic [1:0] StWaitB = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [63:0]     addr_q, addr_d;
  logic [57:0]     rem_q, rem_d;
  logic [OutW-1:0] out_q, out_d;
  logic [OutW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LenW-1:0] beat_q, beat_d;
  logic [LenW-1:0] fifo_q [MAX_OUTSTANDING];

  logic [LenW-1:0] room, cap, len, head_len;
  logic            fifo_ne, aw_fire, w_fire, b_fire, push, pop, b_dec;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Beats left before the next 4 KB page: 64 - addr[11:6], always 1..64 for aligned addresses.
  always_comb begin
    room = 7'd64 - {1'b0, addr_q[11:6]};
    cap  = (LenW'(BURST_LEN) < room) ? LenW'(BURST_LEN) : room;
    len  = (rem_q < 58'(cap)) ? rem_q[LenW-1:0] : cap;
  end

  assign m_axi_awvalid = (state_q == StAw) && (rem_q != '0) &&
                         (out_q != OutW'(MAX_OUTSTANDING));
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = (len == '0) ? 8'd0 : {1'b0, len - LenW'(1)};
  assign m_axi_awsize  = 3'd6;
  assign m_axi_awburst = 2'b01;

  assign fifo_ne         = (cnt_q != '0);
  assign head_len        = fifo_q[rd_ptr_q];
  assign m_axi_wvalid    = axis_slv_tvalid & fifo_ne;
  assign axis_slv_tready = m_axi_wready & fifo_ne;
  assign m_axi_wdata     = axis_slv_tdata;
  assign m_axi_wstrb     = '1;
  assign m_axi_wlast     = fifo_ne && (beat_q == head_len - LenW'(1));

  assign busy         = (state_q != StIdle);
  assign m_axi_bready = busy;
  assign wmst_done    = (state_q == StDone);

  assign aw_fire = m_axi_awvalid & m_axi_awready;
  assign w_fire  = m_axi_wvalid & m_axi_wready;
  assign b_fire  = m_axi_bvalid & m_axi_bready;
  assign push    = aw_fire;
  assign pop     = w_fire & m_axi_wlast;
  assign b_dec   = b_fire && (out_q != '0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (wmst_req) begin
          addr_d  = wmst_addr;
          rem_d   = wmst_xfer_size[63:6] + {57'd0, |wmst_xfer_size[5:0]};
          state_d = StAw;
        end
      end
      StAw: begin
        if (rem_q == '0) begin
          state_d = StDone;
        end else if (aw_fire) begin
          addr_d = addr_q + {51'd0, len, 6'd0};
          rem_d  = rem_q - {51'd0, len};
          if (rem_d == '0) state_d = StWaitB;
        end
      end
      StWaitB: begin
        if ((out_q == '0) && !fifo_ne) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (aw_fire && !b_dec)      out_d = out_q + OutW'(1);
    else if (!aw_fire && b_dec) out_d = out_q - OutW'(1);

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + OutW'(1);
    else if (!push && pop) cnt_d = cnt_q - OutW'(1);

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    beat_d = beat_q;
    if (w_fire) beat_d = m_axi_wlast ? '0 : beat_q + LenW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      rem_q    <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      beat_q   <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      if (push) fifo_q[wr_ptr_q] <= len;
    end
  end

`ifdef OFM_WMST_BRESP_CHECK_EN
  logic err_q, err_d;

  // Sticky until the next accepted request; the transfer still completes normally.
  always_comb begin
    err_d = err_q;
    if ((state_q == StIdle) && wmst_req)      err_d = 1'b0;
    else if (b_fire && (m_axi_bresp != 2'b00)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign xfer_err = err_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^m_axi_bresp;
  assign xfer_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ofm_axi_wmst.sv
// Scoreboard bench for ofm_axi_wmst: model-derived AW/W/B expectations, randomized slave and source.
module tb_ofm_axi_wmst;

  localparam int BL   = 16;
  localparam int MAXO = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wmst_req;
  logic [63:0]  wmst_addr, wmst_xfer_size;
  logic         wmst_done, busy, xfer_err;
  logic         axis_slv_tvalid = 1'b0;
  logic         axis_slv_tready;
  logic [511:0] axis_slv_tdata = '0;
  logic         m_axi_awvalid, m_axi_awready = 1'b0;
  logic [63:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_wvalid, m_axi_wready = 1'b0;
  logic [511:0] m_axi_wdata;
  logic [63:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_bvalid = 1'b0, m_axi_bready;
  logic [1:0]   m_axi_bresp = 2'b00;

  ofm_axi_wmst #(.BURST_LEN(BL), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wmst_req(wmst_req), .wmst_addr(wmst_addr), .wmst_xfer_size(wmst_xfer_size),
    .wmst_done(wmst_done), .busy(busy), .xfer_err(xfer_err),
    .axis_slv_tvalid(axis_slv_tvalid), .axis_slv_tready(axis_slv_tready),
    .axis_slv_tdata(axis_slv_tdata),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          len;
  } aw_t;

  aw_t          exp_aw[$];
  int           exp_len[$];
  logic [511:0] exp_w[$];
  logic [1:0]   b_pend[$];

  int checks = 0, failures = 0;
  int cyc = 0;
  int src_left = 0;
  bit rand_en = 0;
  bit abort = 0;
  int b_hold_until = 0, err_idx = -1, burst_idx = 0, w_beat = 0;
  int req_cyc = -100, first_awv_cyc = -1, first_aw_hs_cyc = -1, first_wv_cyc = -1;
  int done_cyc = -1, last_b_cyc = -1, done_cnt = 0, b_cnt = 0, aw_cnt = 0;
  bit err_at_done = 0, err_after_req = 0;
  bit src_hs = 0, b_hs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] rand_word();
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Slave / source driver and monitor: drive just after negedge, sample 1 ns later.
  // A handshake seen at the sample point completes at the following posedge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        axis_slv_tvalid = 1'b0;
        m_axi_awready   = 1'b0;
        m_axi_wready    = 1'b0;
        m_axi_bvalid    = 1'b0;
        src_hs = 0;
        b_hs   = 0;
      end else begin
        if (src_hs) axis_slv_tvalid = 1'b0;
        if (b_hs)   m_axi_bvalid = 1'b0;
        src_hs = 0;
        b_hs   = 0;
        if (!axis_slv_tvalid && src_left > 0 && (!rand_en || $urandom_range(0, 3) != 0)) begin
          axis_slv_tdata  = rand_word();
          axis_slv_tvalid = 1'b1;
          exp_w.push_back(axis_slv_tdata);
          src_left--;
        end
        m_axi_awready = !rand_en || ($urandom_range(0, 1) == 1);
        m_axi_wready  = !rand_en || ($urandom_range(0, 3) != 0);
        if (!m_axi_bvalid && b_pend.size() > 0 && cyc >= b_hold_until &&
            (!rand_en || $urandom_range(0, 2) == 0)) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = b_pend[0];
        end
      end
      #1;
      if (rst_n) begin
        if (wmst_req && !busy) req_cyc = cyc;
        if (cyc == req_cyc + 1) err_after_req = xfer_err;
        if (m_axi_awvalid && first_awv_cyc < 0) first_awv_cyc = cyc;
        if (m_axi_wvalid && first_wv_cyc < 0) first_wv_cyc = cyc;

        if (m_axi_awvalid && m_axi_awready) begin
          chk("aw_outstanding_ok", 64'((aw_cnt - b_cnt) < MAXO), 64'd1);
          if (exp_aw.size() == 0) begin
            chk("aw_unexpected", 64'd1, 64'd0);
          end else begin
            aw_t e;
            e = exp_aw.pop_front();
            chk("awaddr", m_axi_awaddr, e.addr);
            chk("awlen", 64'(m_axi_awlen), 64'(e.len - 1));
          end
          if (first_aw_hs_cyc < 0) first_aw_hs_cyc = cyc;
          aw_cnt++;
        end

        src_hs = axis_slv_tvalid && axis_slv_tready;
        if (m_axi_wvalid && m_axi_wready) begin
          bit exp_last;
          chk("tready_with_w", 64'(axis_slv_tready), 64'd1);
          chk("wstrb_ones", 64'(&m_axi_wstrb), 64'd1);
          checks++;
          if (exp_w.size() == 0) begin
            failures++;
            $display("FAIL wdata_extra act=%h exp=none", m_axi_wdata);
          end else begin
            logic [511:0] ew;
            ew = exp_w.pop_front();
            if (m_axi_wdata !== ew) begin
              failures++;
              $display("FAIL wdata act=%h exp=%h", m_axi_wdata, ew);
            end
          end
          exp_last = (exp_len.size() > 0) && (w_beat == exp_len[0] - 1);
          chk("wlast", 64'(m_axi_wlast), 64'(exp_last));
          if (exp_last) begin
            void'(exp_len.pop_front());
            b_pend.push_back((burst_idx == err_idx) ? 2'b10 : 2'b00);
            burst_idx++;
            w_beat = 0;
          end else begin
            w_beat++;
          end
        end

        if (m_axi_bvalid && m_axi_bready) begin
          void'(b_pend.pop_front());
          b_cnt++;
          last_b_cyc = cyc;
          b_hs = 1;
        end

        if (wmst_done) begin
          done_cnt++;
          done_cyc    = cyc;
          err_at_done = xfer_err;
        end
      end
    end
  end

  task automatic run_xfer(input logic [63:0] addr, input logic [63:0] size, input int eidx,
                          input int hold, input bit rnd, input bit poke);
    logic [63:0] a;
    longint      rem;
    int          nb, len, room, n;
    bit          exp_err;
    nb  = 0;
    a   = addr;
    rem = longint'(size / 64) + ((size % 64 != 0) ? 1 : 0);
    while (rem > 0) begin
      len  = (rem > BL) ? BL : int'(rem);
      room = (4096 - int'(a % 4096)) / 64;
      if (len > room) len = room;
      exp_aw.push_back('{addr: a, len: len});
      exp_len.push_back(len);
      a   = a + 64'(len * 64);
      rem = rem - len;
      nb++;
    end

    @(negedge clk);
    done_cnt = 0; b_cnt = 0; aw_cnt = 0; burst_idx = 0; w_beat = 0;
    first_awv_cyc = -1; first_aw_hs_cyc = -1; first_wv_cyc = -1; last_b_cyc = -1;
    req_cyc = -100; err_after_req = 0;
    err_idx = eidx;
    rand_en = rnd;
    b_hold_until = cyc + hold;
    src_left = int'((size + 63) / 64);
    wmst_addr = addr;
    wmst_xfer_size = size;
    wmst_req = 1'b1;
    @(negedge clk);
    wmst_req = 1'b0;

    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clk);
      n++;
      if (poke && n == 20) wmst_req = 1'b1;
      if (poke && n == 21) wmst_req = 1'b0;
    end
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL done_timeout act=no_done exp=done addr=%0h size=%0d", addr, size);
      abort = 1;
      return;
    end
    repeat (3) @(negedge clk);
    #2;
    chk("done_pulse_count", 64'(done_cnt), 64'd1);
    chk("aw_left", 64'(exp_aw.size()), 64'd0);
    chk("w_left", 64'(exp_w.size()), 64'd0);
    chk("bursts_left", 64'(exp_len.size()), 64'd0);
    chk("b_count", 64'(b_cnt), 64'(nb));
    chk("busy_after_done", 64'(busy), 64'd0);
    if (nb == 0) begin
      chk("zero_done_latency", 64'(done_cyc - req_cyc), 64'd2);
      chk("zero_no_awvalid", 64'(first_awv_cyc), 64'(-1));
    end else begin
      chk("aw_latency", 64'(first_awv_cyc - req_cyc), 64'd1);
      chk("done_after_last_b", 64'(done_cyc - last_b_cyc), 64'd2);
      chk("w_after_first_aw", 64'(first_wv_cyc > first_aw_hs_cyc), 64'd1);
    end
`ifdef OFM_WMST_BRESP_CHECK_EN
    exp_err = (eidx >= 0) && (eidx < nb);
`else
    exp_err = 0;
`endif
    chk("xfer_err_at_done", 64'(err_at_done), 64'(exp_err));
    chk("xfer_err_after_req", 64'(err_after_req), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    wmst_req = 1'b0;
    wmst_addr = '0;
    wmst_xfer_size = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("rst_awaddr", m_axi_awaddr, 64'd0);
    chk("rst_awlen", 64'(m_axi_awlen), 64'd0);
    chk("rst_awsize", 64'(m_axi_awsize), 64'd6);
    chk("rst_awburst", 64'(m_axi_awburst), 64'd1);
    chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("rst_wlast", 64'(m_axi_wlast), 64'd0);
    chk("rst_wstrb", m_axi_wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_tready", 64'(axis_slv_tready), 64'd0);
    chk("rst_bready", 64'(m_axi_bready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(wmst_done), 64'd0);
    chk("rst_xfer_err", 64'(xfer_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_xfer(64'h1000, 64'd1024, -1, 0, 0, 0);
    if (!abort) run_xfer(64'h0, 64'd2112, -1, 0, 0, 0);
    if (!abort) run_xfer(64'hF80, 64'd512, -1, 0, 0, 0);
    if (!abort) run_xfer(64'h0, 64'd8192, -1, 50, 1, 1);
    if (!abort) run_xfer(64'h40, 64'd0, -1, 0, 0, 0);
    if (!abort) run_xfer(64'h2000, 64'd2048, 1, 0, 1, 0);
    if (!abort) run_xfer(64'h3040, 64'd300, -1, 0, 1, 0);
    for (int k = 0; k < 6 && !abort; k++) begin
      run_xfer(64'($urandom_range(0, 1023)) << 6, 64'($urandom_range(0, 4000)), -1,
               int'($urandom_range(0, 20)), 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
